// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, NOP word and default PCs.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP                = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID valid/ready pipeline register: load beats a flush, otherwise contents hold.
module if_id_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_pc_plus4,
  input  logic        load_fault,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_fault
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid    <= 1'b0;
      id_instr    <= 32'h0;
      id_pc       <= 32'h0;
      id_pc_plus4 <= 32'h0;
      id_fault    <= 1'b0;
    end else if (load) begin
      id_valid    <= 1'b1;
      id_instr    <= load_instr;
      id_pc       <= load_pc;
      id_pc_plus4 <= load_pc_plus4;
      id_fault    <= load_fault;
    end else if (flush) begin
      // Data fields keep their last value; only the valid bit retires the beat.
      id_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC and RST/RUN/HALT FSM, drives the ROM, feeds IF/ID.
// Optional misaligned-redirect fault beats are enabled by defining IF_ALIGN_CHECK_EN.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          ROM_WORDS  = 64,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_fault
);

  fetch_state_t state, state_next;
  logic [31:0]  pc;
  logic [31:0]  redirect_target;
  logic         misaligned;
  logic         in_range;
  logic         redirect_en;
  logic         capture;
  logic         fault_load;
  logic [31:0]  load_pc;

  assign rom_addr    = pc;
  assign in_range    = {2'b00, pc[31:2]} < 32'(ROM_WORDS);
  assign redirect_en = redirect_valid && (state != ST_RST);

`ifdef IF_ALIGN_CHECK_EN
  assign misaligned      = redirect_pc[1:0] != 2'b00;
  assign redirect_target = misaligned ? EXC_VECTOR : redirect_pc;
`else
  logic unused_cfg;
  assign misaligned      = 1'b0;
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign unused_cfg      = ^{EXC_VECTOR, redirect_pc[1:0]};
`endif

  assign fault_load = redirect_en && misaligned;
  assign capture    = (state == ST_RUN) && in_range && !redirect_en && (!id_valid || id_ready);
  assign load_pc    = fault_load ? redirect_pc : pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RST;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      if (redirect_en)  pc <= redirect_target;
      else if (capture) pc <= pc + 32'd4;
    end
  end

  // NOTE: assigning the default first keeps always_comb free of inferred latches.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_RST:  state_next = ST_RUN;
      ST_RUN:  if (!redirect_en && !in_range) state_next = ST_HALT;
      ST_HALT: if (redirect_en) state_next = ST_RUN;
      default: state_next = ST_RST;
    endcase
  end

  // A redirect always retires the current beat; a fault redirect reloads it instead.
  if_id_reg u_if_id_reg (
    .clk           (clk),
    .reset         (reset),
    .load          (capture || fault_load),
    .flush         (redirect_en || id_ready),
    .load_instr    (fault_load ? NOP : rom_data),
    .load_pc       (load_pc),
    .load_pc_plus4 (load_pc + 32'd4),
    .load_fault    (fault_load),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc_plus4   (id_pc_plus4),
    .id_fault      (id_fault)
  );

endmodule
